// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// The hazard compare lives here so the top reads as a pure sequencing FSM.
package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hsc_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
    logic halted;
  } ctrl_t;

  // Free-running pipeline: every register loads, nothing is squashed.
  localparam ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_write: 1'b1,
    id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_flush: 1'b0, halted: 1'b0
  };

  // Front end frozen while MEM waits; WB is fed bubbles so nothing retires twice.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
    id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_flush: 1'b1, halted: 1'b0
  };

  localparam ctrl_t CTRL_HALT = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
    id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_flush: 1'b1, halted: 1'b1
  };

  // A load in EX feeding a source register of the ID instruction; $0 is never a dependency.
  function automatic logic load_use_hazard(
    input logic                 ex_mem_read,
    input logic [REG_IDX_W-1:0] ex_rt,
    input logic [REG_IDX_W-1:0] id_rs,
    input logic [REG_IDX_W-1:0] id_rt,
    input logic                 id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mem_wait_timer.sv
// Counts consecutive data-memory stall cycles; flags the last cycle allowed
// before the controller gives up and halts.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  localparam int CNT_BITS = $clog2(MEM_TIMEOUT);

  logic [CNT_BITS-1:0] wait_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (inc) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (wait_cnt == CNT_BITS'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hold/bubble sequencing for a 5-stage pipeline: load-use, taken branch, and
// multi-cycle data memory with a timeout halt. HSC_PERF_CNT_EN adds perf counters.
module hazard_stall_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 ex_branch_tkn,
  input  logic                 mem_access,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_flush,
  output logic                 ex_mem_write,
  output logic                 mem_wb_flush,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  hsc_state_e state_q, state_d;
  ctrl_t      ctrl;
  logic       mem_stall;
  logic       load_use;
  logic       timeout;

  assign mem_stall = (state_q != HALT) && mem_access && !dmem_ready;
  assign load_use  = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!mem_stall),
    .inc     (mem_stall),
    .timeout (timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_RUN;
    case (state_q)
      HALT: begin
        ctrl = CTRL_HALT;
      end
      default: begin
        if (mem_stall) begin
          // Load-use and branch are deliberately ignored until memory releases.
          ctrl    = CTRL_FREEZE;
          state_d = timeout ? HALT : MEM_WAIT;
        end else begin
          state_d = RUN;
          if (ex_branch_tkn) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (load_use) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
      end
    endcase
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign halted       = ctrl.halted;

`ifdef HSC_PERF_CNT_EN
  logic             live;
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // A load-use squashed by a taken branch never stalled, so it is not counted.
  assign live      = (state_q != HALT) && !mem_stall;
  assign stall_evt = mem_stall || (live && load_use && !ex_branch_tkn);
  assign flush_evt = live && ex_branch_tkn;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a random
// run, all against an event-level reference model (honours HSC_PERF_CNT_EN).
module tb_hazard_stall_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Expected control vectors: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, halted}
  localparam logic [7:0] V_NORMAL = 8'b1101_0100;
  localparam logic [7:0] V_LDUSE  = 8'b0001_1100;
  localparam logic [7:0] V_BRANCH = 8'b1111_1100;
  localparam logic [7:0] V_FREEZE = 8'b0000_0010;
  localparam logic [7:0] V_HALT   = 8'b0000_0011;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, ex_branch_tkn, mem_access, dmem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic             ex_mem_write, mem_wb_flush, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive stall cycles so far, sticky halt, event totals.
  int     stall_run;
  bit     m_halted;
  longint m_stall;
  longint m_flush;

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .ex_branch_tkn (ex_branch_tkn),
    .mem_access    (mem_access),
    .dmem_ready    (dmem_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_write   (id_ex_write),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_write  (ex_mem_write),
    .mem_wb_flush  (mem_wb_flush),
    .halted        (halted),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] got_vec();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
            ex_mem_write, mem_wb_flush, halted};
  endfunction

  function automatic bit is_load_use();
    return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic logic [7:0] model_exp();
    if (m_halted) return V_HALT;
    if (mem_access && !dmem_ready) return V_FREEZE;
    if (ex_branch_tkn) return V_BRANCH;
    if (is_load_use()) return V_LDUSE;
    return V_NORMAL;
  endfunction

  function automatic logic [CNT_W-1:0] exp_stall_cnt();
`ifdef HSC_PERF_CNT_EN
    return CNT_W'(m_stall);
`else
    return '0;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] exp_flush_cnt();
`ifdef HSC_PERF_CNT_EN
    return CNT_W'(m_flush);
`else
    return '0;
`endif
  endfunction

  // Applies the rules for the cycle whose inputs are currently driven.
  function automatic void model_update();
    if (reset) begin
      stall_run = 0;
      m_halted  = 1'b0;
      m_stall   = 0;
      m_flush   = 0;
    end else if (!m_halted) begin
      if (mem_access && !dmem_ready) begin
        if (m_stall < CNT_MAX) m_stall++;
        stall_run++;
        if (stall_run == MEM_TIMEOUT) m_halted = 1'b1;
      end else begin
        stall_run = 0;
        if (ex_branch_tkn) begin
          if (m_flush < CNT_MAX) m_flush++;
        end else if (is_load_use()) begin
          if (m_stall < CNT_MAX) m_stall++;
        end
      end
    end
  endfunction

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_tkn = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic advance();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    advance();
    advance();
    reset = 1'b0;
    settle();
    checks++;
    if (got_vec() !== V_NORMAL) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", got_vec(), V_NORMAL);
    end
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
    advance();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    settle();
    checks++;
    if (got_vec() !== V_LDUSE || got_vec() !== model_exp()) begin
      errors++;
      $display("FAIL load_use_rs: got %b want %b", got_vec(), V_LDUSE);
    end
    advance();
    ex_mem_read = 1'b0;  // the load has moved on to MEM
    settle();
    checks++;
    if (got_vec() !== V_NORMAL) begin
      errors++;
      $display("FAIL load_use_release: got %b want %b", got_vec(), V_NORMAL);
    end
    advance();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    settle();
    checks++;
    if (got_vec() !== V_NORMAL) begin
      errors++;
      $display("FAIL load_use_reg0: got %b want %b", got_vec(), V_NORMAL);
    end
    advance();
    ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 1'b0;
    settle();
    checks++;
    if (got_vec() !== V_NORMAL) begin
      errors++;
      $display("FAIL load_use_rt_unused: got %b want %b", got_vec(), V_NORMAL);
    end
    advance();
    id_uses_rt = 1'b1;
    settle();
    checks++;
    if (got_vec() !== V_LDUSE) begin
      errors++;
      $display("FAIL load_use_rt: got %b want %b", got_vec(), V_LDUSE);
    end
    advance();
  endtask

  task automatic test_mem_stall();
    set_idle();
    mem_access = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;  // load-use hidden by the freeze
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (got_vec() !== V_FREEZE) begin
        errors++;
        $display("FAIL mem_freeze[%0d]: got %b want %b", i, got_vec(), V_FREEZE);
      end
      advance();
    end
    dmem_ready = 1'b1;
    settle();
    checks++;
    if (got_vec() !== V_LDUSE) begin
      errors++;
      $display("FAIL mem_release_lduse: got %b want %b", got_vec(), V_LDUSE);
    end
    advance();
    set_idle();
    mem_access = 1'b1;
    advance();
    advance();
    mem_access = 1'b0;  // access abandoned while waiting
    settle();
    checks++;
    if (got_vec() !== V_NORMAL) begin
      errors++;
      $display("FAIL mem_access_drop: got %b want %b", got_vec(), V_NORMAL);
    end
    advance();
  endtask

  task automatic test_branch();
    set_idle();
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; ex_branch_tkn = 1'b1;
    settle();
    checks++;
    if (got_vec() !== V_BRANCH) begin
      errors++;
      $display("FAIL branch_over_lduse: got %b want %b", got_vec(), V_BRANCH);
    end
    advance();
    set_idle();
    ex_branch_tkn = 1'b1; mem_access = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (got_vec() !== V_FREEZE) begin
        errors++;
        $display("FAIL branch_in_stall[%0d]: got %b want %b", i, got_vec(), V_FREEZE);
      end
      advance();
    end
    dmem_ready = 1'b1;
    settle();
    checks++;
    if (got_vec() !== V_BRANCH) begin
      errors++;
      $display("FAIL branch_after_ready: got %b want %b", got_vec(), V_BRANCH);
    end
    advance();
    set_idle();
    settle();
    checks++;
    if (flush_count !== exp_flush_cnt()) begin
      errors++;
      $display("FAIL flush_count: got %0d want %0d", flush_count, exp_flush_cnt());
    end
    advance();
  endtask

  task automatic test_timeout();
    // Reset mid-wait must clear the wait count.
    set_idle();
    mem_access = 1'b1;
    repeat (5) advance();
    reset = 1'b1;
    advance();
    reset = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) advance();
    settle();
    checks++;
    if (got_vec() !== V_FREEZE) begin
      errors++;
      $display("FAIL reset_mid_wait: got %b want %b", got_vec(), V_FREEZE);
    end
    // Fresh counter baseline, then exactly MEM_TIMEOUT stalled cycles.
    reset = 1'b1;
    advance();
    reset = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      settle();
      if (i == MEM_TIMEOUT - 1) begin
        checks++;
        if (got_vec() !== V_FREEZE) begin
          errors++;
          $display("FAIL last_wait_cycle: got %b want %b", got_vec(), V_FREEZE);
        end
      end
      advance();
    end
    dmem_ready = 1'b1;  // too late: only reset leaves HALT
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (got_vec() !== V_HALT) begin
        errors++;
        $display("FAIL halt[%0d]: got %b want %b", i, got_vec(), V_HALT);
      end
      advance();
    end
    settle();
    checks++;
`ifdef HSC_PERF_CNT_EN
    if (stall_cycles !== CNT_W'(MEM_TIMEOUT)) begin
      errors++;
      $display("FAIL stall_cycles_timeout: got %0d want %0d", stall_cycles, MEM_TIMEOUT);
    end
`else
    if (stall_cycles !== '0) begin
      errors++;
      $display("FAIL stall_cycles_absent: got %0d want 0", stall_cycles);
    end
`endif
    reset = 1'b1;
    set_idle();
    advance();
    reset = 1'b0;
    settle();
    checks++;
    if (got_vec() !== V_NORMAL) begin
      errors++;
      $display("FAIL halt_reset: got %b want %b", got_vec(), V_NORMAL);
    end
    advance();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 59) == 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rt         = 5'($urandom_range(0, 3));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_mem_read   = ($urandom_range(0, 2) != 0);
      ex_branch_tkn = ($urandom_range(0, 4) == 0);
      mem_access    = ($urandom_range(0, 2) != 0);
      dmem_ready    = ($urandom_range(0, 9) < 2);
      settle();
      checks++;
      if (got_vec() !== model_exp() || stall_cycles !== exp_stall_cnt() ||
          flush_count !== exp_flush_cnt()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: got %b/%0d/%0d want %b/%0d/%0d", i, got_vec(),
                   stall_cycles, flush_count, model_exp(), exp_stall_cnt(), exp_flush_cnt());
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    stall_run = 0;
    m_halted  = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
    reset     = 1'b1;
    set_idle();
    @(posedge clock);
    #1;
    test_reset();
    test_load_use();
    test_mem_stall();
    test_branch();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
